// File: rtl/multi_port_line_adapter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_port_line_adapter_pkg
// Description : Shared types and geometry helpers for the multi-port line
//               adapter (FSM state encoding, beat count, line offset bits).
// Revision    : 1.0 - initial release
// ============================================================================
package multi_port_line_adapter_pkg;

  // Adapter controller states, 2-bit explicit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Integer type used for the derived geometry localparams.
  typedef int unsigned geom_t;

  // Number of memory beats per cacheline.
  function automatic geom_t calc_beats(input geom_t line_width, input geom_t burst_width);
    return line_width / burst_width;
  endfunction

  // Number of byte-offset address bits covered by one cacheline.
  function automatic geom_t calc_offset_bits(input geom_t line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_port_line_adapter_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_port_line_adapter_rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first
//               requesting port at or after ptr, modulo NUM_PORTS.
// Ports       : req         - per-port request vector
//               ptr         - index of the highest-priority port
//               grant_valid - at least one port is requesting
//               grant_oh    - one-hot grant
//               grant_idx   - binary index of the granted port
// Revision    : 1.0 - initial release
// ============================================================================
module multi_port_line_adapter_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 grant_valid,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic [PTR_W-1:0]     grant_idx
);

  logic [PTR_W-1:0] cand;

  // Walk the ports in circular order starting at ptr; first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_oh    = '0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_PORTS);
      if (!grant_valid && req[cand]) begin
        grant_valid    = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_port_line_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_port_line_adapter
// Description : Serves NUM_PORTS line-granular requesters over one burst
//               memory port. Round-robin arbitration; each granted line is
//               split into (write) or assembled from (read) BEATS beats.
// Ports       : clk, reset_n       - clock, async active-low reset
//               address_i/read_i/write_i/line_i - per-port line requests
//               line_o             - assembled read line (shared)
//               resp_o             - per-port one-cycle completion
//               address_o/read_o/write_o/burst_o - memory request side
//               burst_i/resp_i     - memory read beat and beat acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
module multi_port_line_adapter
  import multi_port_line_adapter_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] address_i,
  input  logic [NUM_PORTS-1:0]            read_i,
  input  logic [NUM_PORTS-1:0]            write_i,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0]           line_o,
  output logic [NUM_PORTS-1:0]            resp_o,
  output logic [ADDR_WIDTH-1:0]           address_o,
  output logic                            read_o,
  output logic                            write_o,
  output logic [BURST_WIDTH-1:0]          burst_o,
  input  logic [BURST_WIDTH-1:0]          burst_i,
  input  logic                            resp_i
);

  localparam int BEATS       = int'(calc_beats(LINE_WIDTH, BURST_WIDTH));
  localparam int OFFSET_BITS = int'(calc_offset_bits(LINE_WIDTH));
  localparam int CNT_W       = $clog2(BEATS) + 1;
  localparam int PTR_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'((1 << OFFSET_BITS) - 1));

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [NUM_PORTS-1:0]    gnt_oh_q, gnt_oh_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wbuf_q, wbuf_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_PORTS-1:0]    req;
  logic                    grant_valid;
  logic [NUM_PORTS-1:0]    grant_oh;
  logic [PTR_W-1:0]        grant_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LINE_WIDTH-1:0]   sel_line;
  logic                    sel_wr;

  assign req = read_i | write_i;

  multi_port_line_adapter_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx)
  );

  // One-hot mux of the granted port's request. A port raising both read and
  // write is treated as a write.
  always_comb begin
    sel_addr = '0;
    sel_line = '0;
    sel_wr   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_oh[p]) begin
        sel_addr = address_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_line = line_i[p*LINE_WIDTH +: LINE_WIDTH];
        sel_wr   = write_i[p];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gnt_idx_d = grant_idx;
          gnt_oh_d  = grant_oh;
          addr_d    = sel_addr & ADDR_MASK;
          wbuf_d    = sel_line;
          cnt_d     = '0;
          state_d   = sel_wr ? WRITE : READ;
        end
      end
      READ: begin
        // Beats land directly in the output line register, so line_o only
        // changes once the next read's first beat arrives.
        if (resp_i) begin
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
              line_d[b*BURST_WIDTH +: BURST_WIDTH] = burst_i;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        // Shift buffer: the current beat is always in the low slice.
        if (resp_i) begin
          wbuf_d = wbuf_q >> BURST_WIDTH;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rr_ptr_d = (gnt_idx_q == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      addr_q    <= '0;
      wbuf_q    <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
    end
  end

  // Memory strobes decode straight from the state register so a reset drops
  // them without waiting for a clock edge.
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE) ? gnt_oh_q : '0;
  assign address_o = addr_q;
  assign burst_o   = (state_q == WRITE) ? wbuf_q[BURST_WIDTH-1:0] : '0;
  assign line_o    = line_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      a_no_read_and_write: assert (!(|(read_i & write_i)));
      a_no_stray_resp: assert (!(resp_i && ((state_q == IDLE) || (state_q == DONE))));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_port_line_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multi_port_line_adapter
// Description : Scoreboard bench. Instance A (2 ports, 64-bit beats) runs
//               directed and random traffic against a behavioural memory;
//               instance B (3 ports, 32-bit beats) runs continuous writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_port_line_adapter;

  localparam int NP = 2, LW = 256, BW = 64, AW = 32, BEATS = LW / BW;
  localparam int NPB = 3, BWB = 32, BEATSB = LW / BWB;
  localparam logic [AW-1:0] LINE_MASK = ~32'h1F;
  localparam logic [LW-1:0] DIR_READ_LINE  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [LW-1:0] DIR_WRITE_LINE = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};

  typedef struct {
    int              port;
    bit              is_wr;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   line;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic               reset_n = 1'b0;
  logic [NP*AW-1:0]   address_i = '0;
  logic [NP-1:0]      read_i = '0, write_i = '0;
  logic [NP*LW-1:0]   line_i = '0;
  logic [LW-1:0]      line_o;
  logic [NP-1:0]      resp_o;
  logic [AW-1:0]      address_o;
  logic               read_o, write_o;
  logic [BW-1:0]      burst_o;
  logic [BW-1:0]      burst_i = '0;
  logic               resp_i = 1'b0;

  multi_port_line_adapter #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o), .read_o(read_o),
    .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i));

  // ---------------- instance B ----------------
  logic               reset_b_n = 1'b0;
  logic [NPB*AW-1:0]  address_b = '0;
  logic [NPB-1:0]     read_b = '0, write_b = '0;
  logic [NPB*LW-1:0]  line_b = '0;
  logic [LW-1:0]      line_ob;
  logic [NPB-1:0]     resp_b;
  logic [AW-1:0]      address_ob;
  logic               read_ob, write_ob;
  logic [BWB-1:0]     burst_ob;
  logic [BWB-1:0]     burst_ib = '0;
  logic               resp_ib = 1'b0;

  multi_port_line_adapter #(.NUM_PORTS(NPB), .LINE_WIDTH(LW), .BURST_WIDTH(BWB), .ADDR_WIDTH(AW)) dut_b (
    .clk(clk), .reset_n(reset_b_n), .address_i(address_b), .read_i(read_b), .write_i(write_b),
    .line_i(line_b), .line_o(line_ob), .resp_o(resp_b), .address_o(address_ob), .read_o(read_ob),
    .write_o(write_ob), .burst_o(burst_ob), .burst_i(burst_ib), .resp_i(resp_ib));

  // ---------------- bookkeeping ----------------
  int n_cmp = 0, n_fail = 0;
  exp_t exp_q[$];
  int model_ptr = 0;
  logic [LW-1:0] last_read_line = '0;
  int stall_mode = 0;
  bit b_done = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0d required 0", name, act);
  endtask

  // Behavioural memory contents: a fixed nibble pattern at 0x1220, a hash elsewhere.
  function automatic logic [BW-1:0] mem_beat(input logic [AW-1:0] a, input int b);
    logic [3:0] nib;
    nib = 4'(b + 1);
    if (a == 32'h0000_1220) return {16{nib}};
    return {a, a ^ (32'h9E37_79B9 * 32'(b + 1))};
  endfunction

  function automatic logic [LW-1:0] exp_read_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int b = 0; b < BEATS; b++) l[b*BW +: BW] = mem_beat(a, b);
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int w = 0; w < LW / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- memory model A ----------------
  int beat_idx = 0, stall_cnt = 0;
  logic [BW-1:0] wr_beats[$];
  bit mem_ack = 1'b0, prev_wr = 1'b0, prev_ack = 1'b0;
  logic [BW-1:0] prev_burst = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      resp_i = 1'b0; beat_idx = 0; stall_cnt = 0; wr_beats.delete();
      prev_wr = 1'b0; prev_ack = 1'b0;
    end else if (read_o || write_o) begin
      if (write_o && prev_wr && !prev_ack) check("burst_stable", burst_o, prev_burst);
      case (stall_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = ($urandom_range(0, 3) != 0);
        default: begin
          if (beat_idx == 2 && stall_cnt < 3) begin
            mem_ack = 1'b0;
            stall_cnt++;
          end else begin
            mem_ack = 1'b1;
          end
        end
      endcase
      resp_i  = mem_ack;
      burst_i = mem_ack ? mem_beat(address_o, beat_idx) : {$urandom, $urandom};
      if (mem_ack) begin
        if (write_o) wr_beats.push_back(burst_o);
        beat_idx++;
      end
      prev_wr = write_o; prev_ack = mem_ack; prev_burst = burst_o;
    end else begin
      resp_i = 1'b0; beat_idx = 0; stall_cnt = 0; prev_wr = 1'b0; prev_ack = 1'b0;
    end
  end

  // ---------------- monitor A ----------------
  bit prev_busy = 1'b0;
  exp_t m_e;
  logic [NP-1:0] m_oh;
  logic [LW-1:0] m_line;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
    end else begin
      if ((read_o || write_o) && !prev_busy) begin
        if (exp_q.size() == 0) fail_now("unexpected_burst", 1);
        else begin
          check("burst_addr", address_o, exp_q[0].addr);
          check("burst_op", write_o, exp_q[0].is_wr);
        end
      end
      if (write_o) check("line_hold", line_o, last_read_line);
      if (resp_o != '0) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp", int'(resp_o));
        else begin
          m_e = exp_q.pop_front();
          m_oh = '0;
          m_oh[m_e.port] = 1'b1;
          check("resp_port", resp_o, m_oh);
          if (m_e.is_wr) begin
            check("write_beats", wr_beats.size(), BEATS);
            for (int b = 0; b < BEATS; b++) m_line[b*BW +: BW] = (b < wr_beats.size()) ? wr_beats[b] : '0;
            check("write_data", m_line, m_e.line);
            wr_beats.delete();
          end else begin
            check("read_line", line_o, m_e.line);
            last_read_line = m_e.line;
          end
        end
      end
      prev_busy = read_o || write_o;
    end
  end

  // Issue simultaneous requests on the ports in mask; the expected service
  // order is the circular order starting at the model's round-robin pointer.
  task automatic run_batch(input logic [NP-1:0] mask, input logic [NP-1:0] wr,
                           input logic [NP*AW-1:0] addrs, input logic [NP*LW-1:0] lines,
                           output int latency);
    logic [NP-1:0] pending;
    int last, cyc;
    exp_t e;
    latency = -1;
    last = model_ptr;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (model_ptr + k) % NP;
      if (mask[p]) begin
        e.port  = p;
        e.is_wr = wr[p];
        e.addr  = addrs[p*AW +: AW] & LINE_MASK;
        e.line  = wr[p] ? lines[p*LW +: LW] : exp_read_line(addrs[p*AW +: AW] & LINE_MASK);
        exp_q.push_back(e);
        last = p;
      end
    end
    model_ptr = (last + 1) % NP;
    @(negedge clk);
    address_i = addrs; line_i = lines;
    read_i = mask & ~wr; write_i = mask & wr;
    pending = mask; cyc = 0;
    while (pending != '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (pending[p] && resp_o[p]) begin
          pending[p] = 1'b0; read_i[p] = 1'b0; write_i[p] = 1'b0;
          if (latency < 0) latency = cyc;
        end
      end
    end
    if (pending != '0) fail_now("batch_timeout", int'(pending));
  endtask

  // ---------------- main stimulus (instance A) ----------------
  int lat, cyc;
  initial begin
    repeat (2) @(negedge clk);
    check("rst_read_o", read_o, 0);
    check("rst_write_o", write_o, 0);
    check("rst_resp_o", resp_o, 0);
    check("rst_address_o", address_o, 0);
    check("rst_burst_o", burst_o, 0);
    check("rst_line_o", line_o, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed read: port 0, unaligned address, back-to-back beats.
    stall_mode = 0;
    run_batch(2'b01, 2'b00, {32'h0, 32'h0000_1234}, '0, lat);
    check("read_latency", lat, BEATS + 1);
    check("read_line_const", line_o, DIR_READ_LINE);
    check("read_address", address_o, 32'h0000_1220);

    // Directed write: port 1 with a 3-cycle stall after two beats.
    stall_mode = 2;
    run_batch(2'b10, 2'b10, {32'h0000_8047, 32'h0}, {DIR_WRITE_LINE, 256'h0}, lat);
    check("line_after_write", line_o, DIR_READ_LINE);

    // Contention rounds.
    stall_mode = 0;
    run_batch(2'b11, 2'b00, {$urandom, $urandom}, '0, lat);
    run_batch(2'b11, 2'b01, {$urandom, $urandom}, {rand_line(), rand_line()}, lat);
    run_batch(2'b01, 2'b00, {$urandom, $urandom}, '0, lat);
    run_batch(2'b11, 2'b10, {$urandom, $urandom}, {rand_line(), rand_line()}, lat);

    // Reset in the middle of a read burst (round-robin pointer is 1 here).
    begin
      exp_t e;
      e.port = 0; e.is_wr = 1'b0; e.addr = 32'h0004_5600; e.line = exp_read_line(32'h0004_5600);
      exp_q.push_back(e);
      @(negedge clk);
      address_i[AW-1:0] = 32'h0004_5610; read_i = 2'b01;
      cyc = 0;
      while (cyc < 50) begin
        @(posedge clk);
        cyc++;
        if (beat_idx >= 2) break;
      end
      if (cyc >= 50) fail_now("reset_wait_timeout", cyc);
      #2;
      check("pre_reset_read_o", read_o, 1);
      reset_n = 1'b0;
      #1;
      check("reset_read_o_async", read_o, 0);
      check("reset_resp_o", resp_o, 0);
      check("reset_line_o", line_o, 0);
      exp_q.delete();
      read_i = '0;
      last_read_line = '0;
      model_ptr = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
    end
    run_batch(2'b11, 2'b00, {$urandom, $urandom}, '0, lat);

    // Randomised traffic with random beat gaps.
    stall_mode = 1;
    for (int i = 0; i < 20; i++) begin
      run_batch(NP'($urandom_range(1, 3)), NP'($urandom), {$urandom, $urandom},
                {rand_line(), rand_line()}, lat);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) fail_now("leftover_expected", exp_q.size());

    cyc = 0;
    while (!b_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!b_done) fail_now("b_timeout", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- instance B: three ports writing continuously ----------------
  logic [BWB-1:0] beats_b[$];
  logic [AW-1:0]  burst_addr_b = '0;
  logic [LW-1:0]  b_line;
  logic [NPB-1:0] b_oh;
  initial begin
    int exp_port, bursts, bcyc;
    for (int p = 0; p < NPB; p++) begin
      address_b[p*AW +: AW] = $urandom;
      line_b[p*LW +: LW] = rand_line();
    end
    repeat (3) @(negedge clk);
    reset_b_n = 1'b1;
    write_b = '1;
    exp_port = 0; bursts = 0; bcyc = 0;
    while (bursts < 6 && bcyc < 2000) begin
      @(negedge clk);
      bcyc++;
      resp_ib  = write_ob;
      burst_ib = $urandom;
      if (write_ob) begin
        beats_b.push_back(burst_ob);
        if (beats_b.size() == 1) burst_addr_b = address_ob;
      end
      if (resp_b != '0) begin
        b_oh = '0;
        b_oh[exp_port] = 1'b1;
        check("b_grant_order", resp_b, b_oh);
        check("b_beat_count", beats_b.size(), BEATSB);
        check("b_addr_aligned", burst_addr_b[4:0], 0);
        check("b_addr", burst_addr_b, address_b[exp_port*AW +: AW] & LINE_MASK);
        for (int b = 0; b < BEATSB; b++) b_line[b*BWB +: BWB] = (b < beats_b.size()) ? beats_b[b] : '0;
        check("b_write_data", b_line, line_b[exp_port*LW +: LW]);
        address_b[exp_port*AW +: AW] = $urandom;
        line_b[exp_port*LW +: LW] = rand_line();
        beats_b.delete();
        exp_port = (exp_port + 1) % NPB;
        bursts++;
      end
    end
    if (bursts < 6) fail_now("b_burst_timeout", bursts);
    write_b = '0;
    b_done = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/multi_port_line_adapter.md
Name: multi_port_line_adapter

Overview:
- Parametrised successor to the single-port cacheline adaptor.
- Serves NUM_PORTS line-granular requesters (split I-cache/D-cache, later a prefetcher) over one burst memory port.
- Round-robin arbitration between requesters; each granted line is split into or assembled from LINE_WIDTH/BURST_WIDTH beats.
- Sits between the cache level(s) and the bmem interface at the top of the design.

Parameters:
NUM_PORTS, 2, number of line-side requesters (1..8)
LINE_WIDTH, 256, cacheline width in bits
BURST_WIDTH, 64, memory beat width; LINE_WIDTH must be an integer multiple, with BEATS = LINE_WIDTH/BURST_WIDTH >= 2
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
address_i  in  NUM_PORTS x ADDR_WIDTH  per-port line address
read_i  in  NUM_PORTS  per-port line read request
write_i  in  NUM_PORTS  per-port line write request
line_i  in  NUM_PORTS x LINE_WIDTH  per-port line to write
line_o  out  LINE_WIDTH  assembled read line, shared by all ports
resp_o  out  NUM_PORTS  per-port one-cycle completion
address_o  out  ADDR_WIDTH  line-aligned memory address
read_o  out  1  memory burst read
write_o  out  1  memory burst write
burst_o  out  BURST_WIDTH  write beat
burst_i  in  BURST_WIDTH  read beat
resp_i  in  1  memory beat acknowledge, once per beat

Behaviour:
Reset state (reset_n low, takes effect immediately, independent of clk):
- FSM in IDLE; rr_ptr=0; beat count=0.
- read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0.
- A reset during a burst aborts it; memory sees read_o/write_o drop asynchronously; no resp_o is issued.

FSM states and transitions:
- IDLE: req[p] = read_i[p] | write_i[p]. Grant the first requesting port at or after rr_ptr, modulo NUM_PORTS.
- On grant, register g, address_i[g] with its low log2(LINE_WIDTH/8) bits cleared, op, and line_i[g] into the shift buffer. Go to READ or WRITE. No request: stay in IDLE.
- READ: read_o=1, address_o held. Each cycle with resp_i=1 stores burst_i into beat slot cnt (beat 0 = bits [BURST_WIDTH-1:0]) and increments cnt. When cnt reaches BEATS, go to DONE.
- WRITE: write_o=1, burst_o = beat cnt of the buffered line. Each cycle with resp_i=1 advances cnt. On the last beat, go to DONE.
- DONE: resp_o[g]=1 for exactly one cycle, read_o=write_o=0, rr_ptr <= (g+1) mod NUM_PORTS. Go to IDLE.
- The requester drops its request at the edge ending DONE, so IDLE never re-grants a completed request.

Timing and handshake rules:
- Gaps between beats (resp_i low) are legal; the FSM holds and outputs stay stable.
- Minimum latency: request seen in IDLE (cycle 0) -> read_o/write_o in cycle 1 -> resp_o at cycle BEATS+1 with back-to-back resp_i.
- line_o is registered. It is valid from DONE of a read and held until the next read's first beat arrives. It is not updated by writes.
- Requesters hold address_i, op and line_i stable until their resp_o. Changes on non-granted ports never disturb the active burst.
- read_i and write_i both high on one port is illegal (simulation assertion). It is serviced as a write.
- resp_i in IDLE or DONE is ignored (simulation assertion).
- Beat counter width is $clog2(BEATS)+1; it never wraps mid-burst.

Decomposition:
- The shared package holds the state enum (IDLE, READ, WRITE, DONE) and a typedef for the BEATS and offset-bit localparams helper.
- One sub-module: rr_arbiter. Parameter NUM_PORTS. Inputs req, ptr. Outputs grant_valid and a one-hot and index grant. Purely combinational.

Test Plan:
- Port 0 read, address_i=0x0000_1234, LINE 256/BURST 64. Beats 0x11..1, 0x22..2, 0x33..3, 0x44..4 back-to-back. -> address_o=0x0000_1220; line_o={0x44..4,0x33..3,0x22..2,0x11..1}; resp_o=2'b01 exactly at cycle 5.
- Port 1 write, line 0xDDDD..CCCC..BBBB..AAAA. resp_i held low 3 cycles between beats 1 and 2. -> burst_o shows beats AAAA, BBBB, CCCC, DDDD in order; burst_o stable during stall; resp_o=2'b10 once.
- Ports 0 and 1 both read in the same cycle, rr_ptr=0. -> port 0 served, then port 1. In the next contention round port 0 is served first again only if rr_ptr wrapped to 0. No resp_o on the waiting port before its burst.
- Reset_n pulsed low after the 2nd read beat. -> read_o drops without waiting for clk; no resp_o. A fresh request after reset completes normally with rr_ptr=0.
- NUM_PORTS=3, BURST_WIDTH=32, all three writing continuously. -> grants rotate 0,1,2,0; each burst is 8 beats; address_o is 32-byte aligned.
- Port 0 read completes, then port 1 write. -> line_o keeps the port-0 read data through the entire write.
